// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the mouse transmitter and receiver: transmitter FSM states,
// ERROR_CODE values and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_RELEASE
  } ps2_tx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NO_ACK  = 2'b10;
  // Stop-bit error; only the receiver reports it.
  localparam logic [1:0] ERR_STOP    = 2'b11;

  // Parity bit that makes the total count of ones (byte + parity) odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchroniser for one PS/2 line plus a 1->0 edge detector on the synced value.
// Flops reset to 1 (idle line level) so reset release never produces a spurious edge.
module ps2_edge_sync (
  input  logic CLK,
  input  logic RESET_N,
  input  logic LINE_IN,
  output logic LINE_SYNC,
  output logic FALL
);

  logic meta_q, sync_q, prev_q;

  // Synchroniser chain and previous-value register for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= LINE_IN;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign LINE_SYNC = sync_q;
  assign FALL      = prev_q & ~sync_q;

endmodule

// File: rtl/mouse_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first, odd parity,
// stop bit and (optionally) a device ACK check.
// Build option: define MOUSE_TX_ACK_CHECK_EN to sample the device ACK on the 11th falling
// edge and wait for line release; otherwise BYTE_SENT follows the stop-bit edge.
module mouse_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES    = 12000,
  parameter int unsigned START_HOLD_CYCLES = 20,
  parameter int unsigned TIMEOUT_CYCLES    = 50000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic [1:0] ERROR_CODE
);

  localparam logic [15:0] INHIBIT_LAST = 16'(INHIBIT_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST    = 16'(START_HOLD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          clk_en_q, clk_en_d;
  logic          data_en_q, data_en_d;
  logic          sent_q, sent_d;
  logic [1:0]    err_q, err_d;

  logic clk_sync, clk_fall, data_sync, data_fall_unused;

  ps2_edge_sync u_clk_sync (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .LINE_IN   (CLK_MOUSE_IN),
    .LINE_SYNC (clk_sync),
    .FALL      (clk_fall)
  );

  ps2_edge_sync u_data_sync (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .LINE_IN   (DATA_MOUSE_IN),
    .LINE_SYNC (data_sync),
    .FALL      (data_fall_unused)
  );

  // State and datapath registers; async reset releases both lines at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      bit_cnt_q <= 3'd0;
      cnt_q     <= 16'd0;
      tmo_q     <= 16'd0;
      clk_en_q  <= 1'b0;
      data_en_q <= 1'b0;
      sent_q    <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      clk_en_q  <= clk_en_d;
      data_en_q <= data_en_d;
      sent_q    <= sent_d;
      err_q     <= err_d;
    end
  end

  // Next-state, line drive and counter logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    clk_en_d  = clk_en_q;
    data_en_d = data_en_q;
    sent_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        clk_en_d  = 1'b0;
        data_en_d = 1'b0;
        if (SEND_BYTE) begin
          shift_d  = BYTE_TO_SEND;
          parity_d = odd_parity(BYTE_TO_SEND);
          err_d    = ERR_NONE;
          clk_en_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q >= INHIBIT_LAST) begin
          data_en_d = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (cnt_q >= HOLD_LAST) begin
          clk_en_d  = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (clk_fall) begin
          data_en_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (clk_fall) begin
          data_en_d = ~parity_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (clk_fall) begin
          data_en_d = 1'b0;
`ifdef MOUSE_TX_ACK_CHECK_EN
          state_d   = ACK;
`else
          sent_d    = 1'b1;
          state_d   = IDLE;
`endif
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (!data_sync) begin
            state_d = WAIT_RELEASE;
          end else begin
            err_d   = ERR_NO_ACK;
            state_d = IDLE;
          end
        end
      end
      WAIT_RELEASE: begin
        if (clk_sync && data_sync) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Device stopped clocking: abandon the frame.
    if ((state_q inside {DATA, PARITY, STOP, ACK, WAIT_RELEASE}) && !clk_fall &&
        (tmo_q >= TIMEOUT_LAST)) begin
      state_d   = IDLE;
      clk_en_d  = 1'b0;
      data_en_d = 1'b0;
      sent_d    = 1'b0;
      err_d     = ERR_TIMEOUT;
    end

    // Phase counter times INHIBIT/START; timeout counter also restarts on each clock edge.
    if (state_d != state_q) begin
      cnt_d = 16'd0;
      tmo_d = 16'd0;
    end else begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      if (clk_fall) tmo_d = 16'd0;
      else          tmo_d = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
    end
  end

  assign CLK_MOUSE_OUT_EN  = clk_en_q;
  assign DATA_MOUSE_OUT_EN = data_en_q;
  assign BUSY              = (state_q != IDLE);
  assign BYTE_SENT         = sent_q;
  assign ERROR_CODE        = err_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Directed bench for mouse_transmitter with a PS/2 device model on open-drain lines.
// Timing parameters are scaled down so the whole run stays short.
module tb_mouse_transmitter;

  localparam int unsigned INH  = 100;
  localparam int unsigned HOLD = 20;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned HALF = 40;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       SEND_BYTE = 1'b0;
  logic [7:0] BYTE_TO_SEND = 8'h00;
  logic       CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, BUSY, BYTE_SENT;
  logic [1:0] ERROR_CODE;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_line, data_line;

  int vec_cnt = 0;
  int err_cnt = 0;
  int sent_cnt = 0;

  assign clk_line  = ~(CLK_MOUSE_OUT_EN | dev_clk_low);
  assign data_line = ~(DATA_MOUSE_OUT_EN | dev_data_low);

  always #5 CLK = ~CLK;

  mouse_transmitter #(
    .INHIBIT_CYCLES    (INH),
    .START_HOLD_CYCLES (HOLD),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .CLK_MOUSE_IN      (clk_line),
    .DATA_MOUSE_IN     (data_line),
    .CLK_MOUSE_OUT_EN  (CLK_MOUSE_OUT_EN),
    .DATA_MOUSE_OUT_EN (DATA_MOUSE_OUT_EN),
    .SEND_BYTE         (SEND_BYTE),
    .BYTE_TO_SEND      (BYTE_TO_SEND),
    .BUSY              (BUSY),
    .BYTE_SENT         (BYTE_SENT),
    .ERROR_CODE        (ERROR_CODE)
  );

  always @(negedge CLK) if (BYTE_SENT) sent_cnt <= sent_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    SEND_BYTE    = 1'b1;
    BYTE_TO_SEND = b;
    @(negedge CLK);
    SEND_BYTE    = 1'b0;
    BYTE_TO_SEND = 8'h00;
  endtask

  // Cycles of clock-only inhibit, then cycles of clock+data low before clock release.
  task automatic meas_rts(output int inh, output int hold);
    inh = 0;
    while (!DATA_MOUSE_OUT_EN && inh < int'(INH + 50)) begin
      @(negedge CLK);
      inh++;
    end
    hold = 0;
    while (CLK_MOUSE_OUT_EN && hold < int'(HOLD + 50)) begin
      @(negedge CLK);
      hold++;
    end
  endtask

  task automatic wait_rts(output bit ok);
    int n;
    n = 0;
    while (!(DATA_MOUSE_OUT_EN && !CLK_MOUSE_OUT_EN) && n < int'(INH + HOLD + 100)) begin
      @(negedge CLK);
      n++;
    end
    ok = DATA_MOUSE_OUT_EN && !CLK_MOUSE_OUT_EN;
    if (!ok) check("rts_wait", 32'(ok), 32'd1);
  endtask

  // Device clock pulses; data sampled at each rising edge, ACK driven before pulse 11.
  task automatic dev_pulses(input int npulse, input bit ack, output logic [10:0] smp);
    smp = '0;
    for (int i = 0; i < npulse; i++) begin
      if (i == 10 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge CLK);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge CLK);
      dev_clk_low = 1'b0;
      smp[i] = data_line;
    end
    if (npulse == 11) begin
      repeat (HALF) @(negedge CLK);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic device_frame(input bit ack, output logic [10:0] smp);
    bit ok;
    smp = '0;
    wait_rts(ok);
    if (ok) begin
      check("start_bit", 32'(data_line), 32'd0);
      dev_pulses(11, ack, smp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("idle_wait", 32'(BUSY), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int inh, hold, base, n;
    bit ok;
    logic [10:0] smp;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_clk_en", 32'(CLK_MOUSE_OUT_EN), 32'd0);
    check("rst_data_en", 32'(DATA_MOUSE_OUT_EN), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_sent", 32'(BYTE_SENT), 32'd0);
    check("rst_err", 32'(ERROR_CODE), 32'd0);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);

    // 0xF4 with ACK: timing of request-to-send and full frame
    base = sent_cnt;
    send(8'hF4);
    check("f4_busy", 32'(BUSY), 32'd1);
    check("f4_clk_en", 32'(CLK_MOUSE_OUT_EN), 32'd1);
    check("f4_data_en", 32'(DATA_MOUSE_OUT_EN), 32'd0);
    meas_rts(inh, hold);
    check("f4_inhibit_cycles", 32'(inh), 32'(INH));
    check("f4_hold_cycles", 32'(hold), 32'(HOLD));
    device_frame(1'b1, smp);
    check("f4_data", 32'(smp[7:0]), 32'h0000_00F4);
    check("f4_parity", 32'(smp[8]), 32'd0);
    check("f4_stop", 32'(smp[9]), 32'd1);
    wait_idle(200);
    repeat (5) @(negedge CLK);
    check("f4_sent", 32'(sent_cnt - base), 32'd1);
    check("f4_err", 32'(ERROR_CODE), 32'd0);

    // 0xFF: parity bit 1
    base = sent_cnt;
    send(8'hFF);
    device_frame(1'b1, smp);
    check("ff_data", 32'(smp[7:0]), 32'h0000_00FF);
    check("ff_parity", 32'(smp[8]), 32'd1);
    check("ff_stop", 32'(smp[9]), 32'd1);
    wait_idle(200);
    repeat (5) @(negedge CLK);
    check("ff_sent", 32'(sent_cnt - base), 32'd1);
    check("ff_err", 32'(ERROR_CODE), 32'd0);

    // Device never clocks: timeout after release of the clock line
    base = sent_cnt;
    send(8'h5A);
    wait_rts(ok);
    n = 0;
    while (BUSY && n < int'(TMO + 100)) begin
      @(negedge CLK);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_err", 32'(ERROR_CODE), 32'd1);
    check("tmo_clk_en", 32'(CLK_MOUSE_OUT_EN), 32'd0);
    check("tmo_data_en", 32'(DATA_MOUSE_OUT_EN), 32'd0);
    check("tmo_busy", 32'(BUSY), 32'd0);
    check("tmo_sent", 32'(sent_cnt - base), 32'd0);

    // Device leaves data high on the 11th edge
    base = sent_cnt;
    send(8'hF4);
    check("noack_err_cleared", 32'(ERROR_CODE), 32'd0);
    device_frame(1'b0, smp);
    wait_idle(200);
    repeat (5) @(negedge CLK);
`ifdef MOUSE_TX_ACK_CHECK_EN
    check("noack_err", 32'(ERROR_CODE), 32'd2);
    check("noack_sent", 32'(sent_cnt - base), 32'd0);
`else
    check("noack_err", 32'(ERROR_CODE), 32'd0);
    check("noack_sent", 32'(sent_cnt - base), 32'd1);
`endif

    // Second request during DATA is ignored
    base = sent_cnt;
    send(8'hA5);
    check("a5_err_cleared", 32'(ERROR_CODE), 32'd0);
    fork
      device_frame(1'b1, smp);
      begin
        repeat (INH + HOLD + 300) @(negedge CLK);
        SEND_BYTE    = 1'b1;
        BYTE_TO_SEND = 8'h00;
        @(negedge CLK);
        SEND_BYTE    = 1'b0;
      end
    join
    check("a5_data", 32'(smp[7:0]), 32'h0000_00A5);
    check("a5_parity", 32'(smp[8]), 32'd1);
    wait_idle(200);
    repeat (5) @(negedge CLK);
    check("a5_sent", 32'(sent_cnt - base), 32'd1);
    check("a5_err", 32'(ERROR_CODE), 32'd0);

    // Asynchronous reset after the 4th data bit
    send(8'hF4);
    wait_rts(ok);
    dev_pulses(4, 1'b0, smp);
    check("rst_mid_bits", 32'(smp[3:0]), 32'h0000_0004);
    repeat (5) @(negedge CLK);
    check("rst_mid_pre_data_en", 32'(DATA_MOUSE_OUT_EN), 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("rst_mid_clk_en", 32'(CLK_MOUSE_OUT_EN), 32'd0);
    check("rst_mid_data_en", 32'(DATA_MOUSE_OUT_EN), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    check("rst_mid_err", 32'(ERROR_CODE), 32'd0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    base = sent_cnt;
    send(8'hF4);
    device_frame(1'b1, smp);
    check("post_rst_data", 32'(smp[7:0]), 32'h0000_00F4);
    check("post_rst_parity", 32'(smp[8]), 32'd0);
    wait_idle(200);
    repeat (5) @(negedge CLK);
    check("post_rst_sent", 32'(sent_cnt - base), 32'd1);
    check("post_rst_err", 32'(ERROR_CODE), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
